// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures writeback control/data with stall and flush,
// extracts and extends load lanes, selects the writeback value and counts retirements.
module mem_wb_stage #(
    parameter int DW        = 32,
    parameter int RAW       = 5,
    parameter int ZERO_HARD = 1,
    parameter int CNTW      = 32
) (
    input  logic            clk,
    input  logic            res,
    input  logic            iStall,
    input  logic            iFlush,
    input  logic            iValid,
    input  logic            iRegWrite,
    input  logic            iMemtoReg,
    input  logic [RAW-1:0]  iRegDest,
    input  logic [DW-1:0]   iMemAdd,
    input  logic [DW-1:0]   iMemData,
    input  logic [1:0]      iLdSize,
    input  logic            iLdUns,
    input  logic            iCntClr,
    output logic            oValid,
    output logic            oRegWrite,
    output logic [RAW-1:0]  oRegDest,
    output logic [DW-1:0]   oWbData,
    output logic            oMisalign,
    output logic [CNTW-1:0] oRetired
);

    localparam int L  = $clog2(DW / 8);
    localparam int NB = DW / 8;
    localparam int NH = DW / 16;
    localparam int NW = DW / 32;

    logic            valid_reg;
    logic            reg_write_reg;
    logic            mem_to_reg_reg;
    logic [RAW-1:0]  reg_dest_reg;
    logic [DW-1:0]   mem_add_reg;
    logic [DW-1:0]   mem_data_reg;
    logic [1:0]      ld_size_reg;
    logic            ld_uns_reg;
    logic [CNTW-1:0] retired_reg;

    // Flush only kills the valid/write bits; data fields keep their old contents.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            valid_reg      <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            reg_dest_reg   <= '0;
            mem_add_reg    <= '0;
            mem_data_reg   <= '0;
            ld_size_reg    <= 2'b00;
            ld_uns_reg     <= 1'b0;
        end else if (iFlush) begin
            valid_reg     <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (!iStall) begin
            valid_reg      <= iValid;
            reg_write_reg  <= iRegWrite;
            mem_to_reg_reg <= iMemtoReg;
            reg_dest_reg   <= iRegDest;
            mem_add_reg    <= iMemAdd;
            mem_data_reg   <= iMemData;
            ld_size_reg    <= iLdSize;
            ld_uns_reg     <= iLdUns;
        end
    end

    // An entry retires on the edge it leaves the stage, so a stalled entry counts once.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            retired_reg <= '0;
        end else if (iCntClr) begin
            retired_reg <= '0;
        end else if (valid_reg && !iStall) begin
            retired_reg <= retired_reg + CNTW'(1);
        end
    end

    logic [7:0]  byte_lane [NB];
    logic [15:0] half_lane [NH];
    logic [31:0] word_lane [NW];

    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        assign byte_lane[gi] = mem_data_reg[8*gi +: 8];
    end
    for (genvar gi = 0; gi < NH; gi++) begin : g_half
        assign half_lane[gi] = mem_data_reg[16*gi +: 16];
    end
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
        assign word_lane[gi] = mem_data_reg[32*gi +: 32];
    end

    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   word_sel;
    logic [DW-1:0] byte_ext;
    logic [DW-1:0] half_ext;
    logic [DW-1:0] word_ext;
    logic [DW-1:0] load_val;

    // Low address bits below the access size are ignored: the address rounds down.
    assign byte_sel = byte_lane[mem_add_reg[L-1:0]];
    assign half_sel = half_lane[mem_add_reg[L-1:1]];

    assign byte_ext = {{(DW-8){byte_sel[7] & ~ld_uns_reg}}, byte_sel};
    assign half_ext = {{(DW-16){half_sel[15] & ~ld_uns_reg}}, half_sel};

    if (DW == 64) begin : g_word64
        assign word_sel = word_lane[mem_add_reg[2]];
        assign word_ext = {{(DW-32){word_sel[31] & ~ld_uns_reg}}, word_sel};
    end else begin : g_word32
        assign word_sel = word_lane[0];
        assign word_ext = word_sel;
    end

    always_comb begin
        load_val = mem_data_reg;
        case (ld_size_reg)
            2'b00:   load_val = byte_ext;
            2'b01:   load_val = half_ext;
            2'b10:   load_val = word_ext;
            default: load_val = mem_data_reg;
        endcase
    end

    logic [L-1:0] low_add;
    logic         low_bits_set;

    assign low_add = mem_add_reg[L-1:0];

    always_comb begin
        low_bits_set = 1'b0;
        case (ld_size_reg)
            2'b00:   low_bits_set = 1'b0;
            2'b01:   low_bits_set = low_add[0];
            2'b10:   low_bits_set = |low_add[1:0];
            default: low_bits_set = |low_add;
        endcase
    end

    logic dest_is_hard_zero;

    assign dest_is_hard_zero = (ZERO_HARD != 0) && (reg_dest_reg == '0);

    assign oValid    = valid_reg;
    assign oRegWrite = valid_reg && reg_write_reg && !dest_is_hard_zero;
    assign oRegDest  = reg_dest_reg;
    assign oWbData   = mem_to_reg_reg ? load_val : mem_add_reg;
    assign oMisalign = valid_reg && mem_to_reg_reg && low_bits_set;
    assign oRetired  = retired_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random traffic against an arithmetic
// reference model of the stage contents, writeback value and retirement count.
module tb_mem_wb_stage;

    localparam int DW   = 32;
    localparam int RAW  = 5;
    localparam int CNTW = 10;

    logic            clk = 1'b0;
    logic            res = 1'b1;
    logic            iStall = 1'b0;
    logic            iFlush = 1'b0;
    logic            iValid = 1'b0;
    logic            iRegWrite = 1'b0;
    logic            iMemtoReg = 1'b0;
    logic [RAW-1:0]  iRegDest = '0;
    logic [DW-1:0]   iMemAdd = '0;
    logic [DW-1:0]   iMemData = '0;
    logic [1:0]      iLdSize = 2'b00;
    logic            iLdUns = 1'b0;
    logic            iCntClr = 1'b0;
    logic            oValid;
    logic            oRegWrite;
    logic [RAW-1:0]  oRegDest;
    logic [DW-1:0]   oWbData;
    logic            oMisalign;
    logic [CNTW-1:0] oRetired;

    int checks   = 0;
    int failures = 0;

    mem_wb_stage #(.DW(DW), .RAW(RAW), .ZERO_HARD(1), .CNTW(CNTW)) dut (
        .clk(clk), .res(res), .iStall(iStall), .iFlush(iFlush), .iValid(iValid),
        .iRegWrite(iRegWrite), .iMemtoReg(iMemtoReg), .iRegDest(iRegDest),
        .iMemAdd(iMemAdd), .iMemData(iMemData), .iLdSize(iLdSize), .iLdUns(iLdUns),
        .iCntClr(iCntClr), .oValid(oValid), .oRegWrite(oRegWrite), .oRegDest(oRegDest),
        .oWbData(oWbData), .oMisalign(oMisalign), .oRetired(oRetired)
    );

    always #5 clk = ~clk;

    // Reference model: what the stage currently holds, plus the retirement count.
    logic           m_valid, m_rw, m_mtr, m_uns;
    logic [RAW-1:0] m_dest;
    logic [31:0]    m_add, m_data;
    logic [1:0]     m_size;
    int unsigned    m_cnt;

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mtr = 0; m_uns = 0;
        m_dest = '0; m_add = '0; m_data = '0; m_size = 2'b00; m_cnt = 0;
    endtask

    function automatic int nbytes_of(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_wb();
        int n, off;
        logic [63:0] mask, val;
        if (!m_mtr) return m_add;
        n    = nbytes_of(m_size);
        off  = ((m_add % 4) / n) * n;
        mask = (64'd1 << (8 * n)) - 64'd1;
        val  = ({32'd0, m_data} >> (8 * off)) & mask;
        if (!m_uns && val[8*n-1]) val = val | ~mask;
        return val[31:0];
    endfunction

    function automatic logic exp_mis();
        return m_valid && m_mtr && ((m_add % nbytes_of(m_size)) != 0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(oValid), 64'(m_valid));
        chk({tag, ".regwrite"}, 64'(oRegWrite), 64'(m_valid && m_rw && (m_dest != 0)));
        chk({tag, ".dest"}, 64'(oRegDest), 64'(m_dest));
        chk({tag, ".wbdata"}, 64'(oWbData), 64'(exp_wb()));
        chk({tag, ".misalign"}, 64'(oMisalign), 64'(exp_mis()));
        chk({tag, ".retired"}, 64'(oRetired), 64'(m_cnt));
    endtask

    // One clock: model follows the edge using the inputs it saw, then outputs are compared.
    task automatic step(input string tag);
        @(posedge clk);
        if (iCntClr) m_cnt = 0;
        else if (m_valid && !iStall) m_cnt = (m_cnt + 1) % (1 << CNTW);
        if (iFlush) begin
            m_valid = 0; m_rw = 0;
        end else if (!iStall) begin
            m_valid = iValid; m_rw = iRegWrite; m_mtr = iMemtoReg; m_dest = iRegDest;
            m_add = iMemAdd; m_data = iMemData; m_size = iLdSize; m_uns = iLdUns;
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic v, input logic rw, input logic mtr,
                          input logic [RAW-1:0] dest, input logic [31:0] add,
                          input logic [31:0] data, input logic [1:0] size, input logic uns);
        iValid = v; iRegWrite = rw; iMemtoReg = mtr; iRegDest = dest;
        iMemAdd = add; iMemData = data; iLdSize = size; iLdUns = uns;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"}, 64'(oValid), 64'd0);
        chk({tag, ".regwrite"}, 64'(oRegWrite), 64'd0);
        chk({tag, ".dest"}, 64'(oRegDest), 64'd0);
        chk({tag, ".wbdata"}, 64'(oWbData), 64'd0);
        chk({tag, ".misalign"}, 64'(oMisalign), 64'd0);
        chk({tag, ".retired"}, 64'(oRetired), 64'd0);
    endtask

    logic [CNTW-1:0] r0;
    logic [31:0]     wb0;

    initial begin
        model_reset();
        #1;
        check_zero("reset_init");
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;

        // Byte loads, signed and unsigned
        set_in(1, 1, 1, 5'd7, 32'h1003, 32'h80AA55CC, 2'b00, 0);
        step("byte_s");
        chk("byte_s_const", 64'(oWbData), 64'hFFFFFF80);
        iLdUns = 1;
        step("byte_u");
        chk("byte_u_const", 64'(oWbData), 64'h00000080);

        // Half loads, aligned and misaligned
        set_in(1, 1, 1, 5'd9, 32'h2002, 32'h7FFF1234, 2'b01, 0);
        step("half_al");
        chk("half_al_const", 64'(oWbData), 64'h00007FFF);
        chk("half_al_mis", 64'(oMisalign), 64'd0);
        iMemAdd = 32'h2003;
        step("half_mis");
        chk("half_mis_const", 64'(oWbData), 64'h00007FFF);
        chk("half_mis_flag", 64'(oMisalign), 64'd1);

        // ALU path and x0 suppression
        set_in(1, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0, 2'b10, 0);
        step("alu");
        chk("alu_const", 64'(oWbData), 64'hDEADBEEF);
        chk("alu_rw", 64'(oRegWrite), 64'd1);
        iRegDest = 5'd0;
        step("x0");
        chk("x0_rw", 64'(oRegWrite), 64'd0);

        // Stall holds everything; the entry is counted once when it leaves
        set_in(1, 1, 1, 5'd12, 32'h3001, 32'hA1B2C3D4, 2'b00, 0);
        step("stall_cap");
        r0 = oRetired;
        wb0 = oWbData;
        iStall = 1;
        set_in(1, 1, 0, 5'd3, 32'h12345678, 32'h0, 2'b10, 1);
        for (int k = 0; k < 3; k++) begin
            step("stall_hold");
            chk("stall_cnt_hold", 64'(oRetired), 64'(r0));
            chk("stall_wb_hold", 64'(oWbData), 64'(wb0));
            chk("stall_rw_hold", 64'(oRegWrite), 64'd1);
        end
        iStall = 0;
        step("stall_rel");
        chk("stall_cnt_once", 64'(oRetired), 64'(r0 + 1'b1));

        // Flush wins over stall
        iStall = 1; iFlush = 1;
        step("stall_flush");
        chk("stall_flush_valid", 64'(oValid), 64'd0);
        iStall = 0; iFlush = 0;

        // Asynchronous reset with a valid entry held, then normal capture after release
        set_in(1, 1, 0, 5'd17, 32'hCAFE0001, 32'h0, 2'b10, 0);
        step("pre_reset");
        #3;
        res = 1'b1;
        #1;
        model_reset();
        check_zero("reset_mid");
        @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        step("post_reset");
        chk("post_reset_valid", 64'(oValid), 64'd1);

        // Random traffic
        for (int k = 0; k < 500; k++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                   RAW'($urandom_range(0, 31)), $urandom, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom));
            iStall  = ($urandom_range(0, 3) == 0);
            iFlush  = ($urandom_range(0, 9) == 0);
            iCntClr = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        iStall = 0; iFlush = 0; iCntClr = 0;

        // Clear together with a retirement: clear wins
        set_in(1, 1, 0, 5'd1, 32'h10, 32'h0, 2'b10, 0);
        step("pre_clr");
        iCntClr = 1;
        step("clr_retire");
        chk("clr_retire_zero", 64'(oRetired), 64'd0);
        iCntClr = 0;

        // Counter wrap at 2^CNTW
        for (int k = 0; k < (1 << CNTW) - 2; k++) step("fill");
        chk("fill_count", 64'(oRetired), 64'((1 << CNTW) - 2));
        for (int k = 0; k < 3; k++) step("wrap");
        chk("wrap_count", 64'(oRetired), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline register for the pipelined RISC core, sitting between the data-memory stage and the register-file write port.
- Captures the writeback control and data with stall/flush support and a valid bit.
- Performs load-lane extraction with sign/zero extension and selects the final writeback value (memory or ALU).
- Provides a retired-instruction counter for performance monitoring.

Parameters:
- DW, 32, datapath width; legal values 32 or 64.
- RAW, 5, register-address width.
- ZERO_HARD, 1, when 1, register 0 is hardwired and writes to it are suppressed.
- CNTW, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- iStall  in  1  hold current contents.
- iFlush  in  1  load a bubble.
- iValid  in  1  MEM stage holds a real instruction.
- iRegWrite  in  1  instruction writes the register file.
- iMemtoReg  in  1  1 selects load data, 0 selects ALU result.
- iRegDest  in  RAW  destination register.
- iMemAdd  in  DW  ALU result / memory address.
- iMemData  in  DW  raw memory read word.
- iLdSize  in  2  load size: 00 byte, 01 half, 10 word, 11 full DW.
- iLdUns  in  1  1 means zero-extend, 0 means sign-extend.
- iCntClr  in  1  synchronous clear of the counter.
- oValid  out  1  stage holds a valid instruction.
- oRegWrite  out  1  qualified register-file write enable.
- oRegDest  out  RAW  write address.
- oWbData  out  DW  final writeback value.
- oMisalign  out  1  load address is not aligned to iLdSize.
- oRetired  out  CNTW  retired-instruction count.

Behaviour:
- Reset: on res high, asynchronously clear all state. All outputs read 0 while res is high and after release: oValid, oRegWrite, oRegDest, oWbData, oMisalign, oRetired.
- Capture priority on each posedge clk:
  1. flush: the valid bit and the stored reg-write become 0. Data fields are don't-care but held.
  2. else stall: all fields hold.
  3. else: capture all i* inputs.
- flush wins over stall when both are asserted.
- Latency: one cycle. Inputs captured at edge N appear on the outputs after edge N.
- oValid is the registered valid bit.
- oRegWrite = valid AND stored reg-write AND NOT (ZERO_HARD AND oRegDest == 0).
- oRegDest is the registered destination.
- oWbData is combinational from registered fields:
  - stored MemtoReg = 0: the stored MemAdd.
  - stored MemtoReg = 1: the extracted load value.
- Lane extraction uses the low address bits. Let L = log2(DW/8).
  - Byte: lane = MemAdd[L-1:0]; take bits [8*lane+7 : 8*lane].
  - Half: lane = MemAdd[L-1:1]; take a 16-bit lane.
  - Word (DW=64): lane = MemAdd[2].
  - Word (DW=32), and size 11: the full word.
  - Size 11 with DW=32 behaves as word.
  - Extension to DW: zero if stored LdUns, else sign from the lane MSB.
- oMisalign = valid AND MemtoReg AND any address bit below the access size is set.
  - Extraction ignores those bits, i.e. the address is rounded down.
  - No trap is raised.
- Counter:
  - Increments by 1 at each edge where oValid = 1 and iStall = 0. Each instruction is counted exactly once, even across stalls.
  - Wraps modulo 2^CNTW.
  - iCntClr sets it to 0, and takes priority over an increment in the same cycle.
- Bubbles: flushed or invalid entries never assert oRegWrite or oMisalign and are not counted.
- Stall with a valid entry: oRegWrite stays asserted with the same address and data, so repeated writes are idempotent.
- Reset mid-stall or mid-flush: reset dominates immediately. The first edge after release captures normally.

Test Plan:
- Reset: assert res asynchronously between edges with a valid entry held -> all outputs 0 immediately; oRetired = 0.
- Byte load:
  - iValid=1, iMemtoReg=1, iLdSize=00, iLdUns=0, iMemAdd=0x1003, iMemData=0x80AA55CC -> next cycle oWbData=0xFFFFFF80.
  - Same with iLdUns=1 -> oWbData=0x00000080.
- Half load: iLdSize=01, iMemAdd=0x2002, iMemData=0x7FFF1234 -> oWbData=0x00007FFF. With iMemAdd=0x2003 -> same data and oMisalign=1.
- ALU path and x0 suppression:
  - iMemtoReg=0, iMemAdd=0xDEADBEEF, iRegDest=5 -> oWbData=0xDEADBEEF, oRegWrite=1.
  - iRegDest=0 -> oRegWrite=0.
- Stall/flush:
  - Valid entry, then 3 cycles of iStall=1 -> outputs constant and oRetired increments by 1 total.
  - iStall=1 and iFlush=1 together -> oValid=0 next cycle.
- Counter: preload 2^32-2 retirements via forced state, retire 3 -> oRetired=1. iCntClr together with a retirement -> oRetired=0.
